conv_array_pot: RTL and testbench



---
 rtl/conv_pot_pkg.sv | 34 +++
 rtl/conv_array_pot_mult.sv | 15 +
 rtl/conv_array_pot.sv | 152 +++++++++++++++
 tb/tb_conv_array_pot.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pot_pkg.sv
// rtl/conv_pot_pkg.sv - weight field layout, controller state type and power-of-two term helper
package conv_pot_pkg;

    localparam int WGT_W   = 5;
    localparam int W_EN    = 4;
    localparam int W_SIGN  = 3;
    localparam int W_SHIFT = 0;
    localparam int SHIFT_W = 3;

    // Widest pixel and term the helper handles; callers truncate to their AW.
    localparam int PIX_MAX_W  = 32;
    localparam int TERM_MAX_W = 48;

    typedef enum logic {LOAD, RUN} state_t;

    // Wide signed term; truncating it to AW bits gives the correct value modulo 2^AW.
    function automatic logic signed [TERM_MAX_W-1:0] pot_term(
        input logic [PIX_MAX_W-1:0] pixel,
        input logic [WGT_W-1:0]     weight
    );
        logic signed [TERM_MAX_W-1:0] mag;
        mag = $signed(TERM_MAX_W'(pixel) << weight[W_SHIFT +: SHIFT_W]);
        if (!weight[W_EN]) begin
            return '0;
        end
        return weight[W_SIGN] ? -mag : mag;
    endfunction

    // Smallest accumulator that never wraps: pixel, 7-bit shift plus sign, K*K-term growth.
    function automatic int min_aw(input int k, input int dw);
        return dw + 8 + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_array_pot_mult.sv
// rtl/conv_array_pot_mult.sv - one shift/negate/zero cell producing a signed AW-bit term
module pot_mult
    import conv_pot_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 24
) (
    input  logic [DW-1:0]        i_pixel,
    input  logic [WGT_W-1:0]     i_weight,
    output logic signed [AW-1:0] o_term
);

    assign o_term = AW'(pot_term(PIX_MAX_W'(i_pixel), i_weight));

endmodule

// File: rtl/conv_array_pot.sv
// rtl/conv_array_pot.sv - KxK power-of-two weight convolution core with load/run controller
module conv_array_pot
    import conv_pot_pkg::*;
#(
    parameter int K  = 5,
    parameter int DW = 8,
    parameter int AW = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_valid,
    input  logic [WGT_W-1:0]     w_data,
    input  logic signed [AW-1:0] bias,
    input  logic                 x_valid,
    input  logic [K*DW-1:0]      x_data,
    input  logic                 x_last,
    output logic                 w_loaded,
    output logic                 x_drop,
    output logic                 y_valid,
    output logic signed [AW-1:0] y_data
);

    localparam int NW = K * K;
    localparam int KW = $clog2(NW);
    localparam int FW = $clog2(K + 1);
    localparam logic [KW-1:0] K_LAST      = KW'(NW - 1);
    localparam logic [FW-1:0] FILL_FULL   = FW'(K);
    localparam logic [FW-1:0] FILL_LAUNCH = FW'(K - 1);

    state_t                r_state;
    logic [KW-1:0]         r_k;
    logic [FW-1:0]         r_fill;
    logic [WGT_W-1:0]      r_wgt  [NW];
    logic [DW-1:0]         r_win  [K][K];
    logic signed [AW-1:0]  r_prod [NW];
    logic                  r_v1;
    logic                  r_v2;

    logic                  w_reload;
    logic                  w_accept;
    logic                  w_launch;
    logic [KW-1:0]         w_widx;
    logic signed [AW-1:0]  w_term [NW];
    logic signed [AW-1:0]  w_sum;

    assign w_reload = (r_state == RUN) && w_valid;
    assign w_accept = (r_state == RUN) && x_valid && !w_valid;
    assign w_launch = w_accept && (r_fill >= FILL_LAUNCH);
    assign w_widx   = w_reload ? '0 : r_k;

    // Controller: weight index, window fill, pipeline valids and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOAD;
            r_k      <= '0;
            r_fill   <= '0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            w_loaded <= 1'b0;
            x_drop   <= 1'b0;
            y_valid  <= 1'b0;
            y_data   <= '0;
        end else begin
            r_v1    <= w_launch;
            r_v2    <= r_v1 && !w_reload;
            y_valid <= r_v2 && !w_reload;
            if (r_v2 && !w_reload) begin
                y_data <= w_sum;
            end

            if (x_valid && !w_accept) begin
                x_drop <= 1'b1;
            end

            // x_last closes the stripe after the beat has been used.
            if (w_accept) begin
                if (x_last) begin
                    r_fill <= '0;
                end else if (r_fill != FILL_FULL) begin
                    r_fill <= r_fill + FW'(1);
                end
            end

            case (r_state)
                LOAD: begin
                    if (w_valid) begin
                        if (r_k == K_LAST) begin
                            r_state  <= RUN;
                            r_k      <= '0;
                            w_loaded <= 1'b1;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end
                end
                RUN: begin
                    if (w_valid) begin
                        r_state  <= LOAD;
                        r_k      <= KW'(1);
                        r_fill   <= '0;
                        w_loaded <= 1'b0;
                    end
                end
            endcase
        end
    end

    // A reload beat always lands in slot 0.
    always_ff @(posedge clk) begin
        if (w_valid) begin
            r_wgt[w_widx] <= w_data;
        end
    end

    // Column c=0 is the oldest, c=K-1 the newest.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= x_data[r*DW +: DW];
            end
        end
    end

    for (genvar gi = 0; gi < NW; gi++) begin : g_tap
        pot_mult #(
            .DW(DW),
            .AW(AW)
        ) u_mult (
            .i_pixel (r_win[gi / K][gi % K]),
            .i_weight(r_wgt[gi]),
            .o_term  (w_term[gi])
        );
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NW; i++) begin
            r_prod[i] <= w_term[i];
        end
    end

    // Wrapping sum; feeds the output register directly.
    always_comb begin
        w_sum = bias;
        for (int i = 0; i < NW; i++) begin
            w_sum = w_sum + r_prod[i];
        end
    end

endmodule

// File: tb/tb_conv_array_pot.sv
// tb/tb_conv_array_pot.sv - randomized scoreboard bench for conv_array_pot at AW=24 and AW=12
module tb_conv_array_pot;

    localparam int K   = 5;
    localparam int DW  = 8;
    localparam int NW  = K * K;
    localparam int AW  = 24;
    localparam int AWS = 12;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  w_valid = 1'b0;
    logic [4:0]            w_data = '0;
    logic signed [AW-1:0]  bias = '0;
    logic                  x_valid = 1'b0;
    logic [K*DW-1:0]       x_data = '0;
    logic                  x_last = 1'b0;

    logic                  w_loaded, x_drop, y_valid;
    logic signed [AW-1:0]  y_data;
    logic                  w_loaded12, x_drop12, y_valid12;
    logic signed [AWS-1:0] y_data12;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        longint val;
        int     cyc;
    } exp_t;
    exp_t exp_q[$];

    int              m_wt[NW];
    int              m_k = 0;
    bit              m_loaded = 1'b0;
    bit              m_drop = 1'b0;
    logic [K*DW-1:0] m_cols[$];

    conv_array_pot #(.K(K), .DW(DW), .AW(AW)) u_dut (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .bias(bias),
        .x_valid(x_valid), .x_data(x_data), .x_last(x_last),
        .w_loaded(w_loaded), .x_drop(x_drop), .y_valid(y_valid), .y_data(y_data)
    );

    conv_array_pot #(.K(K), .DW(DW), .AW(AWS)) u_dut12 (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .bias(bias[AWS-1:0]),
        .x_valid(x_valid), .x_data(x_data), .x_last(x_last),
        .w_loaded(w_loaded12), .x_drop(x_drop12), .y_valid(y_valid12), .y_data(y_data12)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
        end
    endtask

    function automatic int wval(input logic [4:0] w);
        if (!w[4]) return 0;
        return w[3] ? -(1 << w[2:0]) : (1 << w[2:0]);
    endfunction

    function automatic longint model_y();
        longint          s;
        logic [K*DW-1:0] col;
        s = bias;
        for (int c = 0; c < K; c++) begin
            col = m_cols[c];
            for (int r = 0; r < K; r++) begin
                s += longint'(m_wt[r*K + c]) * longint'(col[r*DW +: DW]);
            end
        end
        return s;
    endfunction

    function automatic logic [K*DW-1:0] col_fill(input logic [DW-1:0] v);
        logic [K*DW-1:0] c;
        for (int r = 0; r < K; r++) c[r*DW +: DW] = v;
        return c;
    endfunction

    function automatic logic [K*DW-1:0] rand_col();
        logic [K*DW-1:0] c;
        for (int r = 0; r < K; r++) c[r*DW +: DW] = DW'($urandom);
        return c;
    endfunction

    task automatic flush_pending();
        while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
    endtask

    task automatic step(input bit wv, input logic [4:0] wd, input bit xv,
                        input logic [K*DW-1:0] xd, input bit xl);
        chk("w_loaded", w_loaded, m_loaded);
        chk("w_loaded12", w_loaded12, m_loaded);
        chk("x_drop", x_drop, m_drop);
        chk("x_drop12", x_drop12, m_drop);
        w_valid = wv; w_data = wd; x_valid = xv; x_data = xd; x_last = xl;
        if (xv && (!m_loaded || wv)) m_drop = 1'b1;
        if (wv && m_loaded) begin
            m_wt[0] = wval(wd);
            m_k = 1;
            m_loaded = 1'b0;
            m_cols.delete();
            flush_pending();
        end else if (wv) begin
            m_wt[m_k] = wval(wd);
            m_k++;
            if (m_k == NW) begin
                m_k = 0;
                m_loaded = 1'b1;
            end
        end else if (xv && m_loaded) begin
            m_cols.push_back(xd);
            if (m_cols.size() > K) void'(m_cols.pop_front());
            if (m_cols.size() == K) exp_q.push_back('{val: model_y(), cyc: cyc + 3});
            if (xl) m_cols.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic beat(input logic [K*DW-1:0] xd, input bit xl);
        step(1'b0, 5'd0, 1'b1, xd, xl);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; w_valid = 1'b0; x_valid = 1'b1; x_data = col_fill(8'hAA); x_last = 1'b0;
        m_loaded = 1'b0; m_k = 0; m_drop = 1'b0; m_cols.delete();
        flush_pending();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        chk("rst_w_loaded", w_loaded, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_data", y_data, 0);
        chk("rst_y_data12", y_data12, 0);
        rst = 1'b0; x_valid = 1'b0;
    endtask

    logic [63:0] mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q[0].val;
            void'(exp_q.pop_front());
            chk("y_valid", y_valid, 1);
            chk("y_valid12", y_valid12, 1);
            chk("y_data", {40'd0, y_data}, {40'd0, mon_e[AW-1:0]});
            chk("y_data12", {52'd0, y_data12}, {52'd0, mon_e[AWS-1:0]});
        end else if (y_valid || y_valid12) begin
            chk("spurious_y_valid", {62'd0, y_valid, y_valid12}, 0);
        end
    end

    initial begin
        logic [K*DW-1:0] col;

        do_reset(2);
        beat(col_fill(8'd7), 1'b0);
        idle(1);
        chk("drop_no_weights", x_drop, 1);

        bias = '0;
        for (int i = 0; i < NW; i++) step(1'b1, 5'b10000, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) beat(col_fill(8'd1), 1'b0);
        beat(col_fill(8'd2), 1'b0);
        idle(3);
        chk("ones_y", y_data, 30);

        bias = 24'sd5;
        step(1'b1, 5'b11011, 1'b0, '0, 1'b0);
        for (int i = 1; i < NW; i++) step(1'b1, 5'b00000, 1'b0, '0, 1'b0);
        col = '0;
        col[DW-1:0] = 8'd255;
        beat(col, 1'b0);
        for (int i = 0; i < 4; i++) beat('0, i == 3);
        idle(3);
        chk("enc_y", y_data, -2035);

        bias = $signed(24'($urandom));
        for (int i = 0; i < NW; i++) step(1'b1, 5'($urandom), 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) beat(rand_col(), i == 2);
        for (int i = 0; i < 5; i++) beat(rand_col(), 1'b0);
        idle(3);

        for (int i = 0; i < 6; i++) beat(rand_col(), 1'b0);
        do_reset(1);
        for (int i = 0; i < NW; i++) step(1'b1, 5'($urandom), 1'b0, '0, 1'b0);
        for (int i = 0; i < 7; i++) beat(rand_col(), 1'b0);
        step(1'b1, 5'($urandom), 1'b1, rand_col(), 1'b0);
        chk("reload_drop", x_drop, 1);
        chk("reload_w_loaded", w_loaded, 0);
        for (int i = 1; i < NW; i++) step(1'b1, 5'($urandom), 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) beat(rand_col(), 1'b0);
        idle(3);

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 59) == 0) begin
                bias = $signed(24'($urandom));
                step(1'b1, 5'($urandom), 1'($urandom_range(0, 1)), rand_col(), 1'b0);
                for (int i = 1; i < NW; i++)
                    step(1'b1, 5'($urandom), 1'($urandom_range(0, 3) == 0), rand_col(), 1'b0);
            end else if ($urandom_range(0, 3) != 0) begin
                beat(rand_col(), 1'($urandom_range(0, 9) == 0));
            end else begin
                idle(1);
            end
        end
        idle(3);

        bias = '0;
        for (int i = 0; i < NW; i++) step(1'b1, 5'b10111, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) beat(col_fill(8'd255), i == 4);
        idle(3);
        chk("wrap_y24", y_data, 816000);
        chk("wrap_y12", y_data12, 896);

        idle(2);
        chk("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
